serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits (LEGv8 X-register width); legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only when busy=0.
REQ-005 sub  input  1  0 = ADD (a+b), 1 = SUB (a-b); sampled with start.
REQ-006 a  input  WIDTH  first operand; sampled with start.
REQ-007 b  input  WIDTH  second operand; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; result and flags valid.
REQ-010 result  output  WIDTH  sum or difference, held until the next accepted start.
REQ-011 flag_n, flag_z, flag_c, flag_v  output  1 each  LEGv8 NZCV condition flags for the last result, held with result.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE/DONE with start=1 SHALL latch a, b XOR {WIDTH{sub}}, carry=sub, bit index=0, and go to RUN.
REQ-014 IDLE with start=0 SHALL stay in IDLE; DONE with start=0 SHALL go to IDLE.
REQ-015 RUN SHALL process one bit per cycle, LSB first, through one full-adder cell: sum bit to result[index], carry-out to the carry register.
REQ-016 RUN SHALL last exactly WIDTH cycles; after bit WIDTH-1 the FSM SHALL go to DONE.
REQ-017 Latency: start high at edge k -> busy high for cycles k+1..k+WIDTH -> done high only in cycle k+WIDTH+1.
REQ-018 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-019 start during RUN SHALL be ignored, with no effect on operands or progress.
REQ-020 start in DONE SHALL be accepted (back-to-back): done still pulses that cycle; next RUN begins at the following edge.
REQ-021 The result register SHALL be cleared when an operation is accepted; it updates bit-by-bit during RUN; intermediate values are not valid.
REQ-022 flag_c SHALL be the final carry-out (SUB: 1 = no borrow, ARM convention).
REQ-023 flag_v SHALL be carry-in of bit WIDTH-1 XOR carry-out of bit WIDTH-1.
REQ-024 flag_n SHALL equal result[WIDTH-1].
REQ-025 flag_z SHALL be 1 iff all WIDTH result bits are 0, via a running OR of sum bits (no wide compare).
REQ-026 All four flags SHALL update only on the transition into DONE and hold otherwise.
REQ-027 Arithmetic is modulo 2^WIDTH; overflow is reported only via flags.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, busy=0, done=0, result=0, all flags=0, carry=0, index=0.
REQ-029 reset SHALL take priority over start in any state.
REQ-030 reset mid-RUN SHALL abort the operation with no done pulse.
REQ-031 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-032 A shared definitions file SHALL hold the state encodings (IDLE, RUN, DONE) and the WIDTH default.
REQ-033 One sub-module, full_adder (a, b, c_in, sum, c_out), SHALL be built from two existing half_adder instances plus an OR gate and instantiated once.
REQ-034 The bit index counter SHALL be $clog2(WIDTH) bits wide.

Verification
REQ-035 WIDTH=64, ADD a=5, b=7 -> done at cycle 65 after start; result=12; N=0, Z=0, C=0, V=0.
REQ-036 WIDTH=64, SUB a=3, b=3 -> result=0; Z=1, C=1, N=0, V=0.
REQ-037 WIDTH=8, ADD a=0x7F, b=0x01 -> result=0x80; N=1, V=1, C=0, Z=0.
REQ-038 WIDTH=8, ADD a=0xFF, b=0x01 -> result=0x00; Z=1, C=1, V=0. Follow with SUB a=0x00, b=0x01 -> result=0xFF; N=1, C=0.
REQ-039 WIDTH=8: start in DONE (back-to-back), then start pulsed mid-RUN -> the second op is accepted, the mid-RUN start is ignored, exactly two done pulses.
REQ-040 WIDTH=8: reset at RUN cycle 4 -> no done pulse; all outputs 0 the next cycle; a new ADD 2+2 -> result=4.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// State encodings and the default operand width.
package serial_add_sub_pkg;

  localparam int WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// One-bit full adder built from two half adders and an OR gate.
// Used as the single arithmetic cell of the serial datapath.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (w_s0),
    .carry (w_c0)
  );

  half_adder u_ha1 (
    .a     (w_s0),
    .b     (c_in),
    .sum   (sum),
    .carry (w_c1)
  );

  assign c_out = w_c0 | w_c1;
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial LEGv8 add/subtract, one bit per cycle, LSB first.
// Produces the result plus NZCV flags after WIDTH cycles.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int IW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_any;
  logic             r_flag_n;
  logic             r_flag_z;
  logic             r_flag_c;
  logic             r_flag_v;

  logic w_accept;
  logic w_run;
  logic w_last;
  logic w_sum;
  logic w_cout;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = start & (r_state != ST_RUN);
  assign w_last   = (r_idx == IW'(WIDTH - 1));

  full_adder u_fa (
    .a     (r_a[r_idx]),
    .b     (r_b[r_idx]),
    .c_in  (r_carry),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = start ? ST_RUN : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert b on capture, seed carry with sub.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_any    <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b ^ {WIDTH{sub}};
      r_carry  <= sub;
      r_idx    <= '0;
      r_result <= '0;
      r_any    <= 1'b0;
    end else if (w_run) begin
      r_result[r_idx] <= w_sum;
      r_carry         <= w_cout;
      r_any           <= r_any | w_sum;
      r_idx           <= w_last ? '0 : r_idx + IW'(1);
      if (w_last) begin
        r_flag_n <= w_sum;
        r_flag_z <= ~(r_any | w_sum);
        r_flag_c <= w_cout;
        r_flag_v <= r_carry ^ w_cout;
      end
    end
  end

  assign result = r_result;
  assign flag_n = r_flag_n;
  assign flag_z = r_flag_z;
  assign flag_c = r_flag_c;
  assign flag_v = r_flag_v;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed testbench for serial_add_sub at WIDTH=64 and WIDTH=8.
// Hand-computed results, flags and latencies.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic        rst64 = 1'b1, st64 = 1'b0, sb64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0, res64;
  logic        bz64, dn64, n64, z64, c64, v64;

  logic        rst8 = 1'b1, st8 = 1'b0, sb8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic        bz8, dn8, n8, z8, c8, v8;

  serial_add_sub #(.WIDTH(64)) u64 (
    .clk(clk), .reset(rst64), .start(st64), .sub(sb64),
    .a(a64), .b(b64), .busy(bz64), .done(dn64), .result(res64),
    .flag_n(n64), .flag_z(z64), .flag_c(c64), .flag_v(v64)
  );

  serial_add_sub #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .start(st8), .sub(sb8),
    .a(a8), .b(b8), .busy(bz8), .done(dn8), .result(res8),
    .flag_n(n8), .flag_z(z8), .flag_c(c8), .flag_v(v8)
  );

  task automatic run64(input logic [63:0] ta, input logic [63:0] tb_,
                       input logic ts, output int lat, output int nb);
    @(negedge clk);
    a64 = ta; b64 = tb_; sb64 = ts; st64 = 1'b1;
    @(posedge clk);
    #1 st64 = 1'b0;
    lat = 0; nb = 0;
    while (lat < 70) begin
      @(negedge clk);
      lat++;
      if (bz64) nb++;
      if (dn64) break;
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_,
                      input logic ts, output int lat, output int nb);
    @(negedge clk);
    a8 = ta; b8 = tb_; sb8 = ts; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    lat = 0; nb = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bz8) nb++;
      if (dn8) break;
    end
  endtask

  task automatic test_reset;
    rst64 = 1'b1; rst8 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bz64, dn64, res64, n64, z64, c64, v64} !== '0) begin
      n_fail++;
      $display("FAIL reset64: busy=%b done=%b res=%h nzcv=%b%b%b%b want all 0",
               bz64, dn64, res64, n64, z64, c64, v64);
    end
    n_chk++;
    if ({bz8, dn8, res8, n8, z8, c8, v8} !== '0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b res=%h nzcv=%b%b%b%b want all 0",
               bz8, dn8, res8, n8, z8, c8, v8);
    end
    rst64 = 1'b0; rst8 = 1'b0;
  endtask

  task automatic test_add64;
    int lat, nb;
    run64(64'd5, 64'd7, 1'b0, lat, nb);
    n_chk++;
    if (lat !== 65 || nb !== 64) begin
      n_fail++;
      $display("FAIL add64_latency: done at %0d busy %0d want 65/64", lat, nb);
    end
    n_chk++;
    if (res64 !== 64'd12) begin
      n_fail++;
      $display("FAIL add64_result: got %h want 12", res64);
    end
    n_chk++;
    if ({n64, z64, c64, v64} !== 4'b0000) begin
      n_fail++;
      $display("FAIL add64_flags: nzcv got %b%b%b%b want 0000",
               n64, z64, c64, v64);
    end
  endtask

  task automatic test_sub64_zero;
    int lat, nb;
    run64(64'd3, 64'd3, 1'b1, lat, nb);
    n_chk++;
    if (res64 !== 64'd0 || lat !== 65) begin
      n_fail++;
      $display("FAIL sub64_result: got %h lat %0d want 0 lat 65", res64, lat);
    end
    n_chk++;
    if ({n64, z64, c64, v64} !== 4'b0110) begin
      n_fail++;
      $display("FAIL sub64_flags: nzcv got %b%b%b%b want 0110",
               n64, z64, c64, v64);
    end
  endtask

  task automatic test_overflow8;
    int lat, nb;
    run8(8'h7F, 8'h01, 1'b0, lat, nb);
    n_chk++;
    if (res8 !== 8'h80 || lat !== 9 || nb !== 8) begin
      n_fail++;
      $display("FAIL ovf8_result: got %h lat %0d busy %0d want 80/9/8",
               res8, lat, nb);
    end
    n_chk++;
    if ({n8, z8, c8, v8} !== 4'b1001) begin
      n_fail++;
      $display("FAIL ovf8_flags: nzcv got %b%b%b%b want 1001", n8, z8, c8, v8);
    end
  endtask

  task automatic test_wrap8;
    int lat, nb;
    run8(8'hFF, 8'h01, 1'b0, lat, nb);
    n_chk++;
    if (res8 !== 8'h00 || {n8, z8, c8, v8} !== 4'b0110) begin
      n_fail++;
      $display("FAIL wrap8_add: res %h nzcv %b%b%b%b want 00 0110",
               res8, n8, z8, c8, v8);
    end
    run8(8'h00, 8'h01, 1'b1, lat, nb);
    n_chk++;
    if (res8 !== 8'hFF || {n8, z8, c8, v8} !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap8_sub: res %h nzcv %b%b%b%b want FF 1000",
               res8, n8, z8, c8, v8);
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    int first = 0;
    int second = 0;
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; sb8 = 1'b0; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      st8 = 1'b0;
      if (dn8) begin
        ndone++;
        if (ndone == 1) begin
          first = i;
          n_chk++;
          if (res8 !== 8'd30) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want 1e", res8);
          end
          a8 = 8'd50; b8 = 8'd8; sb8 = 1'b1; st8 = 1'b1;
        end else if (ndone == 2) begin
          second = i;
          n_chk++;
          if (res8 !== 8'd42 || {n8, z8, c8, v8} !== 4'b0010) begin
            n_fail++;
            $display("FAIL b2b_second: res %h nzcv %b%b%b%b want 2a 0010",
                     res8, n8, z8, c8, v8);
          end
        end
      end
      if (ndone == 1 && first != 0 && i == first + 4) begin
        a8 = 8'd1; b8 = 8'd1; sb8 = 1'b0; st8 = 1'b1;
      end
    end
    n_chk++;
    if (ndone !== 2 || first !== 9 || second !== 18) begin
      n_fail++;
      $display("FAIL b2b_pulses: count %0d at %0d,%0d want 2 at 9,18",
               ndone, first, second);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, nb;
    int seen = 0;
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; sb8 = 1'b0; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (4) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    n_chk++;
    if ({bz8, dn8, res8, n8, z8, c8, v8} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy=%b done=%b res=%h nzcv=%b%b%b%b want 0",
               bz8, dn8, res8, n8, z8, c8, v8);
    end
    repeat (12) begin
      @(negedge clk);
      if (dn8 || bz8) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midrst_abort: busy/done seen %0d cycles want 0", seen);
    end
    run8(8'd2, 8'd2, 1'b0, lat, nb);
    n_chk++;
    if (res8 !== 8'd4 || lat !== 9) begin
      n_fail++;
      $display("FAIL midrst_restart: res %h lat %0d want 04 lat 9", res8, lat);
    end
  endtask

  initial begin
    test_reset;
    test_add64;
    test_sub64_zero;
    test_overflow8;
    test_wrap8;
    test_back_to_back;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
